// File: rtl/branch_history_table.sv
// Direct-mapped branch history table: combinational lookup, 1 update/cycle.
// Ports: CLK, nRST, lookup_pc -> predict_hit/taken/target, update_*, flush.
// Optional BHT_BYPASS_EN forwards a same-cycle update to the lookup.
module branch_history_table #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] INIT_CTR = 2'b10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        predict_hit,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [29:0]        tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX-1:0] lk_idx;
  logic [TW-1:0]  lk_tag;
  logic [IDX-1:0] up_idx;
  logic [TW-1:0]  up_tag;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[31:IDX+2];
  assign up_idx = update_pc[IDX+1:2];
  assign up_tag = update_pc[31:IDX+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0],
                            update_target[1:0]};

  logic        up_hit;
  logic        up_we;
  logic [1:0]  up_ctr;
  logic [29:0] up_tgt;

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // A not-taken miss never allocates; flush discards any update.
  assign up_we  = update_en && !flush && (up_hit || update_taken);

  always_comb begin
    up_ctr = INIT_CTR;
    up_tgt = update_target[31:2];
    if (up_hit) begin
      if (update_taken) begin
        up_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11
               : ctr_q[up_idx] + 2'd1;
      end else begin
        up_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00
               : ctr_q[up_idx] - 2'd1;
        up_tgt = tgt_q[up_idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (up_we) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through valid_q.
  always_ff @(posedge CLK) begin
    if (up_we && nRST) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= up_tgt;
      ctr_q[up_idx] <= up_ctr;
    end
  end

  logic        rd_hit;
  logic [1:0]  rd_ctr;
  logic [29:0] rd_tgt;

  always_comb begin
    rd_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    rd_ctr = ctr_q[lk_idx];
    rd_tgt = tgt_q[lk_idx];
`ifdef BHT_BYPASS_EN
    if (nRST && up_we && (update_pc[31:2] == lookup_pc[31:2])) begin
      rd_hit = 1'b1;
      rd_ctr = up_ctr;
      rd_tgt = up_tgt;
    end
`endif
  end

  assign predict_hit    = rd_hit;
  assign predict_taken  = rd_hit & rd_ctr[1];
  assign predict_target = rd_hit ? {rd_tgt, 2'b00} : 32'h0;

endmodule
